// File: rtl/radio_pkg.sv
// Shared radio constants: command format and pulse-width mapping.
// The decoder and the servo generator use the same mapping.
package radio_pkg;
    localparam int CMD_W      = 10;
    localparam int CMD_MAX    = 1023;
    localparam int PWM_OFFSET = 987;
    localparam int WIDTH_W    = 11;

    // 11-bit result so cmd=1023 gives 2010 without wrapping
    function automatic logic [WIDTH_W-1:0] pulse_width(
        input logic [CMD_W-1:0] cmd
    );
        return WIDTH_W'(PWM_OFFSET) + WIDTH_W'(cmd);
    endfunction
endpackage

// File: rtl/servo_chan.sv
// One servo channel: shadow command, width compare and output flop.
// The shadow only changes on a frame wrap, so a running pulse is never cut.
module servo_chan
    import radio_pkg::*;
#(
    parameter int               CW      = 15,
    parameter logic [CMD_W-1:0] RST_VAL = 10'd512
) (
    input  logic             clk_1M,
    input  logic             rst,
    input  logic             load,
    input  logic [CMD_W-1:0] load_val,
    input  logic [CW-1:0]    cnt_nx,
    output logic             pwm
);
    logic [CMD_W-1:0]   shadow;
    logic [CMD_W-1:0]   shadow_nx;
    logic [WIDTH_W-1:0] width_nx;
    logic               pwm_nx;

    // compare against the next count so pwm is a registered output
    always_comb begin
        shadow_nx = load ? load_val : shadow;
        width_nx  = pulse_width(shadow_nx);
        pwm_nx    = (cnt_nx < CW'(width_nx));
    end

    always_ff @(posedge clk_1M or posedge rst) begin
        if (rst) begin
            shadow <= RST_VAL;
            pwm    <= 1'b0;
        end else begin
            shadow <= shadow_nx;
            pwm    <= pwm_nx;
        end
    end
endmodule

// File: rtl/servo_pwm.sv
// Multi-channel servo/ESC pulse generator with stale-command failsafe.
// Frame timing, command hold and timeout live here; channels are servo_chan.
module servo_pwm
    import radio_pkg::*;
#(
    parameter int               NCH            = 4,
    parameter int               FRAME_US       = 20000,
    parameter logic [CMD_W-1:0] RST_VAL        = 10'd512,
    parameter logic [CMD_W-1:0] FAILSAFE_VAL   = 10'd0,
    parameter int               TIMEOUT_FRAMES = 10
) (
    input  logic                 clk_1M,
    input  logic                 rst,
    input  logic [NCH*CMD_W-1:0] cmd_in,
    input  logic                 cmd_valid,
    output logic [NCH-1:0]       pwm_out,
    output logic                 frame_start,
    output logic                 failsafe
);
    localparam int            CW   = $clog2(FRAME_US);
    localparam logic [CW-1:0] LAST = CW'(FRAME_US - 1);
    localparam logic [7:0]    TMO  = 8'(TIMEOUT_FRAMES);

    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nx;
    logic                 wrap;
    logic [7:0]           stale;
    logic                 fs_nx;
    logic [NCH*CMD_W-1:0] hold;

    always_comb begin
        wrap   = (cnt == LAST);
        cnt_nx = wrap ? '0 : cnt + CW'(1);
        fs_nx  = failsafe;
        if (cmd_valid) begin
            fs_nx = 1'b0;
        end else if (wrap && (stale >= TMO - 8'd1)) begin
            fs_nx = 1'b1;
        end
    end

    always_ff @(posedge clk_1M or posedge rst) begin
        if (rst) begin
            cnt      <= LAST;
            stale    <= 8'd0;
            failsafe <= 1'b0;
            hold     <= {NCH{RST_VAL}};
        end else begin
            cnt      <= cnt_nx;
            failsafe <= fs_nx;
            if (cmd_valid) begin
                hold  <= cmd_in;
                stale <= 8'd0;
            end else if (wrap && (stale < TMO)) begin
                stale <= stale + 8'd1;
            end
        end
    end

    assign frame_start = (cnt == '0);

    // shadow sees the pre-edge hold, so a wrap-cycle command waits a frame
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic [CMD_W-1:0] load_val;
        assign load_val = fs_nx ? FAILSAFE_VAL
                                : hold[i*CMD_W +: CMD_W];
        servo_chan #(
            .CW      (CW),
            .RST_VAL (RST_VAL)
        ) u_chan (
            .clk_1M   (clk_1M),
            .rst      (rst),
            .load     (wrap),
            .load_val (load_val),
            .cnt_nx   (cnt_nx),
            .pwm      (pwm_out[i])
        );
    end
endmodule

// File: tb/tb_servo_pwm.sv
// Directed bench for servo_pwm: frame timing, widths, failsafe, reset.
// Short frame keeps the run small; widths come from hand-computed values.
module tb_servo_pwm;
    localparam int NCH = 4;
    localparam int FR  = 2100;

    logic          clk_1M;
    logic          rst;
    logic [39:0]   cmd_in;
    logic          cmd_valid;
    logic [3:0]    pwm_out;
    logic          frame_start;
    logic          failsafe;

    int n_cmp = 0;
    int n_bad = 0;

    servo_pwm #(
        .NCH            (NCH),
        .FRAME_US       (FR),
        .RST_VAL        (10'd512),
        .FAILSAFE_VAL   (10'd0),
        .TIMEOUT_FRAMES (10)
    ) dut (
        .clk_1M      (clk_1M),
        .rst         (rst),
        .cmd_in      (cmd_in),
        .cmd_valid   (cmd_valid),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .failsafe    (failsafe)
    );

    initial clk_1M = 1'b0;
    always #5 clk_1M = ~clk_1M;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at the negedge of a frame's first cycle; returns at the next one.
    task automatic run_frame(input string tag,
                             input int e0, input int e1,
                             input int e2, input int e3,
                             input int inj_k,
                             input logic [39:0] inj_v,
                             input logic exp_fs);
        int  hi[4];
        int  ex[4];
        bit  shape_ok;
        logic fs0;
        ex = '{e0, e1, e2, e3};
        hi = '{default: 0};
        shape_ok = 1'b1;
        fs0 = failsafe;
        chk({tag, "_start"}, {31'd0, frame_start}, 32'd1);
        for (int k = 0; k < FR; k++) begin
            for (int i = 0; i < NCH; i++) begin
                if (pwm_out[i] === 1'b1) begin
                    if (hi[i] != k) shape_ok = 1'b0;
                    hi[i]++;
                end else if (pwm_out[i] !== 1'b0) begin
                    shape_ok = 1'b0;
                end
            end
            if (k > 0 && frame_start !== 1'b0) shape_ok = 1'b0;
            if (inj_k >= 0 && k == inj_k + 1)
                chk({tag, "_fs_clr"}, {31'd0, failsafe}, 32'd0);
            if (k == inj_k) begin
                cmd_in    = inj_v;
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk_1M);
        end
        for (int i = 0; i < NCH; i++)
            chk($sformatf("%s_w%0d", tag, i), hi[i], ex[i]);
        chk({tag, "_shape"}, {31'd0, shape_ok}, 32'd1);
        chk({tag, "_fs"}, {31'd0, fs0}, {31'd0, exp_fs});
    endtask

    initial begin
        logic [39:0] v1, v2, v3;
        v1 = {10'd512, 10'd300, 10'd1023, 10'd0};
        v2 = {10'd512, 10'd300, 10'd1023, 10'd100};
        v3 = {10'd512, 10'd300, 10'd1023, 10'd700};
        rst = 1'b1;
        cmd_in = '0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk_1M);
        chk("rst_pwm", {28'd0, pwm_out}, 32'd0);
        chk("rst_fstart", {31'd0, frame_start}, 32'd0);
        chk("rst_fs", {31'd0, failsafe}, 32'd0);

        rst = 1'b0;
        @(negedge clk_1M);
        chk("rel_pwm", {28'd0, pwm_out}, 32'hF);

        run_frame("f1", 1499, 1499, 1499, 1499, 500, v1, 1'b0);
        run_frame("f2", 987, 2010, 1287, 1499, FR - 1, v2, 1'b0);
        run_frame("f3", 987, 2010, 1287, 1499, -1, v2, 1'b0);
        for (int f = 4; f <= 12; f++)
            run_frame($sformatf("f%0d", f),
                      1087, 2010, 1287, 1499, -1, v2, 1'b0);
        run_frame("f13", 987, 987, 987, 987, 300, v3, 1'b1);
        run_frame("f14", 1687, 2010, 1287, 1499, -1, v3, 1'b0);

        repeat (1200) @(negedge clk_1M);
        chk("pre_rst_pwm", {28'd0, pwm_out}, 32'hF);
        #1 rst = 1'b1;
        #1 chk("async_rst_pwm", {28'd0, pwm_out}, 32'd0);
        repeat (3) @(negedge clk_1M);
        chk("mid_rst_fstart", {31'd0, frame_start}, 32'd0);
        chk("mid_rst_fs", {31'd0, failsafe}, 32'd0);
        rst = 1'b0;
        @(negedge clk_1M);
        chk("rel2_pwm", {28'd0, pwm_out}, 32'hF);
        run_frame("f16", 1499, 1499, 1499, 1499, -1, v3, 1'b0);
        chk("f17_start", {31'd0, frame_start}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
